down_timer_5b: RTL and testbench

- Loadable down-counting timer; the countdown counterpart of the lab loadable up counter.
- Same load/enable/data-in style, plus a start handshake, a terminal-count pulse and a busy flag.
- Sits beside the up counter in the session labs as a timeout/delay generator feeding downstream control logic.

---
 rtl/down_timer_5b.sv | 123 ++++++++++++
 tb/tb_down_timer_5b.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/down_timer_5b.sv
// ---------------------------------------------------------------------------
// down_timer_5b
//   Loadable down-counting timer with a start handshake, a one-cycle
//   terminal-count pulse and a busy flag. It is the countdown companion of
//   the loadable up counter and is used as a timeout/delay generator.
//
//   Optional feature: define DOWN_TIMER_AUTO_RELOAD_EN to reload cnt_out
//   from the shadow register on expiry. The timer then stays in RUN and
//   produces a periodic tc.
//
// Parameters
//   WIDTH    width of cnt_in, cnt_out and the shadow (reload) register
//
// Ports
//   clk      system clock, rising-edge active
//   rst      asynchronous active-low reset
//   cnt_in   value captured on load
//   load     synchronous load strobe, accepted in every state and
//            taking priority over decrement
//   enab     count enable; 0 freezes the count while in RUN
//   start    single-cycle start request, only sampled in IDLE
//   cnt_out  current count, registered
//   tc       terminal-count pulse, registered, one cycle wide
//   busy     high exactly while the state is RUN
// ---------------------------------------------------------------------------
module down_timer_5b #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             load,
    input  logic             enab,
    input  logic             start,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] eff_cnt;

    // A load in the same cycle as start decides which count is used to
    // pick RUN or EXPIRED.
    assign eff_cnt = load ? cnt_in : cnt_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt_out <= '0;
            shadow  <= '0;
            tc      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            tc <= 1'b0;

            // Load is accepted in every state. The state-specific branches
            // below avoid touching cnt_out whenever load is set.
            if (load) begin
                cnt_out <= cnt_in;
                shadow  <= cnt_in;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (eff_cnt != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= EXPIRED;
                            tc    <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (!load && enab) begin
                        if (cnt_out > WIDTH'(1)) begin
                            cnt_out <= cnt_out - WIDTH'(1);
                        end else begin
                            // Expiry covers two cases: the count reaches 1,
                            // or a 0 was loaded while running. A count of 0
                            // never wraps.
                            tc <= 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                            if (shadow != '0) begin
                                cnt_out <= shadow;
                            end else begin
                                cnt_out <= '0;
                                state   <= EXPIRED;
                                busy    <= 1'b0;
                            end
`else
                            cnt_out <= '0;
                            state   <= EXPIRED;
                            busy    <= 1'b0;
`endif
                        end
                    end
                end

                EXPIRED: begin
                    // start is ignored here. Only a load leaves EXPIRED.
                    if (load) state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer_5b.sv
// ---------------------------------------------------------------------------
// tb_down_timer_5b
//   Scoreboard bench for down_timer_5b. The stimulus process drives each
//   cycle's inputs on the falling edge. It advances a behavioural model that
//   tracks "running" and "expired" flags and the remaining count, then queues
//   the expected outputs. A monitor pops one entry after every rising edge
//   and compares it with the DUT outputs.
//
//   Directed sequences follow the timer's use cases. They are followed by
//   randomized traffic. Asynchronous reset is checked directly.
// ---------------------------------------------------------------------------
module tb_down_timer_5b;

    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cnt_in;
    logic         load, enab, start;
    logic [W-1:0] cnt_out;
    logic         tc, busy;

    int vectors = 0;
    int miscompares = 0;

    exp_t sb[$];

    // reference model state
    int m_cnt, m_shadow;
    bit m_running, m_expired, m_tc;

    down_timer_5b #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .load(load), .enab(enab),
        .start(start), .cnt_out(cnt_out), .tc(tc), .busy(busy)
    );

    always #5 clk = ~clk;

    // monitor: one expected entry per rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (cnt_out !== e.cnt || tc !== e.tc || busy !== e.busy) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got cnt=%0d tc=%b busy=%b, want cnt=%0d tc=%b busy=%b",
                         $time, cnt_out, tc, busy, e.cnt, e.tc, e.busy);
            end
        end
    end

    task automatic model_reset();
        m_cnt = 0; m_shadow = 0; m_running = 0; m_expired = 0; m_tc = 0;
    endtask

    // Advance the model by one clock from the timer's behavioural rules.
    task automatic model_step(input bit ld, input bit en, input bit st, input int d);
        m_tc = 0;
        if (ld) begin
            m_cnt = d;
            m_shadow = d;
        end
        if (m_expired) begin
            if (ld) m_expired = 0;
        end else if (m_running) begin
            if (!ld && en) begin
                if (m_cnt >= 2) begin
                    m_cnt = m_cnt - 1;
                end else begin
                    m_tc = 1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    if (m_shadow != 0) m_cnt = m_shadow;
                    else begin m_cnt = 0; m_running = 0; m_expired = 1; end
`else
                    m_cnt = 0; m_running = 0; m_expired = 1;
`endif
                end
            end
        end else if (st) begin
            if (m_cnt != 0) m_running = 1;
            else begin m_expired = 1; m_tc = 1; end
        end
    endtask

    task automatic cyc(input bit ld, input bit en, input bit st, input int d);
        exp_t e;
        @(negedge clk);
        load = ld; enab = en; start = st; cnt_in = W'(d);
        model_step(ld, en, st, d);
        e.cnt = W'(m_cnt); e.tc = m_tc; e.busy = m_running;
        sb.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [W-1:0] c, input logic t, input logic b);
        vectors++;
        if (cnt_out !== c || tc !== t || busy !== b) begin
            miscompares++;
            $display("FAIL %s: got cnt=%0d tc=%b busy=%b, want cnt=%0d tc=%b busy=%b",
                     name, cnt_out, tc, busy, c, t, b);
        end
    endtask

    initial begin
        rst = 1'b0; cnt_in = '0; load = 0; enab = 0; start = 0;
        model_reset();
        #3;
        check_now("reset_initial", 5'd0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1;

        // single shot: load 5 + start, enab high
        cyc(1, 1, 1, 5);
        repeat (7) cyc(0, 1, 0, 0);

        // enable gating: load 4, start, then enab 1,0,0,1,1,1
        cyc(1, 0, 0, 4);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);

        // start with zero count
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0); cyc(0, 1, 0, 0);

        // load 0 while running
        cyc(1, 0, 0, 5);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);

        // maximum delay
        cyc(1, 0, 0, 31);
        cyc(0, 1, 1, 0);
        repeat (33) cyc(0, 1, 0, 0);

        // priority: reload mid-run, then load with start in EXPIRED
        cyc(1, 0, 0, 6);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 9);
        repeat (10) cyc(0, 1, 0, 0);
        cyc(1, 1, 1, 7);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (8) cyc(0, 1, 0, 0);

        // auto-reload stimulus (single-shot when the macro is undefined)
        cyc(1, 0, 0, 3);
        cyc(0, 1, 1, 0);
        repeat (12) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 1);
        repeat (4) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);

        // asynchronous reset while running at 12
        cyc(1, 0, 0, 12);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_now("reset_async", 5'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        check_now("reset_held", 5'd0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1;
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit ld, en, st;
            int d;
            ld = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = $urandom_range(1, 3);
                default: d = $urandom_range(0, 31);
            endcase
            cyc(ld, en, st, d);
        end

        @(posedge clk); #3;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
